// File: rtl/micro_stream.sv
// rtl/micro_stream.sv - microprogrammed datapath with writable control store and valid/ready operand streams
module micro_stream #(
    parameter int WIDTH   = 8,
    parameter int NREGS   = 8,
    parameter int CS_SIZE = 16,
    localparam int RA     = $clog2(NREGS),
    localparam int PCW    = $clog2(CS_SIZE),
    localparam int IW     = 3 + 3 * RA + PCW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [PCW-1:0]   prog_addr,
    input  logic [IW-1:0]    prog_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_IN   = 3'd3;
    localparam logic [2:0] OP_OUT  = 3'd4;
    localparam logic [2:0] OP_BR   = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PCW-1:0]   pc;
    logic [PCW-1:0]   pc_nx;
    logic             done_nx;

    // Control store is not reset: microcode survives rst so a program can be rerun.
    logic [IW-1:0]    cs [CS_SIZE];
    logic [WIDTH-1:0] regs [NREGS];
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;

    logic [IW-1:0]    instr;
    logic [2:0]       op;
    logic [RA-1:0]    fa;
    logic [RA-1:0]    fb;
    logic [RA-1:0]    fc;
    logic [PCW-1:0]   ft;
    logic [1:0]       cond;
    logic             running;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic             alu_en;
    logic             br_taken;

    // Combinational fetch and field decode of the current microinstruction.
    assign instr   = cs[pc];
    assign op      = instr[IW-1 -: 3];
    assign fa      = instr[IW-4 -: RA];
    assign fb      = instr[IW-4-RA -: RA];
    assign fc      = instr[IW-4-2*RA -: RA];
    assign ft      = instr[PCW-1:0];
    assign running = (state == S_RUN);
    assign ra      = regs[fa];
    assign rb      = regs[fb];

    // Branch condition lives in the low two bits of B; a 1-bit B field reads as 0/1 only.
    generate
        if (RA >= 2) begin : g_cond_wide
            assign cond = fb[1:0];
        end else begin : g_cond_narrow
            assign cond = {1'b0, fb};
        end
    endgenerate

    // Stream handshakes are driven purely from state and opcode, never from the peer's signal.
    assign busy      = running;
    assign in_ready  = running && (op == OP_IN);
    assign out_valid = running && (op == OP_OUT);
    assign out_data  = out_valid ? ra : '0;

    // ALU: result, carry/borrow and whether the opcode is a flag-updating ALU op.
    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        alu_en  = 1'b0;
        case (op)
            OP_ADD: begin
                {alu_cy, alu_res} = {1'b0, ra} + {1'b0, rb};
                alu_en            = 1'b1;
            end
            OP_SUB: begin
                alu_res = ra - rb;
                alu_cy  = (ra < rb);
                alu_en  = 1'b1;
            end
            OP_AND: begin
                alu_res = ra & rb;
                alu_en  = 1'b1;
            end
            default: begin
                alu_en = 1'b0;
            end
        endcase
    end

    // Branch condition evaluation against the current flags.
    always_comb begin
        case (cond)
            2'd0:    br_taken = 1'b1;
            2'd1:    br_taken = flag_z;
            2'd2:    br_taken = flag_n;
            default: br_taken = flag_c;
        endcase
    end

    // FSM next-state, sequencing (stalls hold pc) and HALT detection.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    pc_nx    = '0;
                end
            end
            S_RUN: begin
                case (op)
                    OP_IN: begin
                        if (in_valid) begin
                            pc_nx = pc + PCW'(1);
                        end
                    end
                    OP_OUT: begin
                        if (out_ready) begin
                            pc_nx = pc + PCW'(1);
                        end
                    end
                    OP_BR: begin
                        pc_nx = br_taken ? ft : pc + PCW'(1);
                    end
                    OP_HALT: begin
                        state_nx = S_IDLE;
                        pc_nx    = '0;
                        done_nx  = 1'b1;
                    end
                    default: begin
                        pc_nx = pc + PCW'(1);
                    end
                endcase
            end
            default: begin
                state_nx = S_IDLE;
                pc_nx    = '0;
            end
        endcase
    end

    // FSM state register: state, program counter and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            done  <= done_nx;
        end
    end

    // Register file and flags; IN writes only on the handshake cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else if (running) begin
            if (alu_en) begin
                regs[fc] <= alu_res;
                flag_z   <= (alu_res == '0);
                flag_n   <= alu_res[WIDTH-1];
                flag_c   <= alu_cy;
            end else if ((op == OP_IN) && in_valid) begin
                regs[fc] <= in_data;
            end
        end
    end

    // Control-store write port, live only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE)) begin
            cs[prog_addr] <= prog_data;
        end
    end

endmodule
